stream_unpacker: RTL and testbench
==================================

# stream_unpacker

- Pop-side width converter for the crossbar stream path.
- Accepts one wide word of `RATIO` lanes on a valid/ready push port and emits its lanes one at a time on a narrow valid/ready port.
- Each emitted beat carries a last-of-word flag.
- Sits downstream of a stream FIFO's pop port and drains wide buffered entries into narrow consumers, with registered holding state and zero-bubble back-to-back operation.

## Interface

Parameters:

- `OUT_WIDTH`, 8: width of one output beat (one lane).
- `RATIO`, 4: lanes per input word. Power of two, at least 2.

Ports:

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: input word accepted when `in_valid && in_ready`.
- `in_payload` input `OUT_WIDTH*RATIO`: wide word; lane k is bits `[k*OUT_WIDTH +: OUT_WIDTH]`.
- `in_count` input `$clog2(RATIO)+1`: number of valid lanes, counted from lane 0.
- `flush` input 1: synchronous discard of the held word.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: output beat consumed when `out_valid && out_ready`.
- `out_payload` output `OUT_WIDTH`: current lane.
- `out_last` output 1: current beat is the final valid lane of its word.
- `busy` output 1: a word is held (equals `out_valid`).

## Operation

- **State:** holding register `data_q`, remaining-beat counter `rem_q` (`$clog2(RATIO)+1` bits), lane index `idx_q` (`$clog2(RATIO)` bits).
- **States:**
  - EMPTY (`rem_q==0`).
  - HOLD (`rem_q>0`).
- **EMPTY:**
  - `in_ready=1`, `out_valid=0`.
  - On input accept with effective count c > 0: load `data_q`, set `rem_q=c`, set `idx_q` to the first lane, go to HOLD.
- **Effective count:**
  - `in_count > RATIO` saturates to `RATIO`.
  - `in_count == 0`: the word is accepted and dropped; no beat is emitted; state stays EMPTY.
- **HOLD:**
  - `out_valid=1`, `out_payload = data_q` lane `idx_q`, `out_last = (rem_q==1)`.
  - On output handshake with `rem_q>1`: decrement `rem_q`, advance `idx_q` by one lane.
- **Last beat:**
  - `in_ready = out_ready && (rem_q==1)`, so the next word loads in the same cycle the last beat leaves. No idle cycle.
  - If no input word arrives, go to EMPTY.
- **Stability:**
  - `out_payload` and `out_last` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake, except on `flush` or reset.
- **Flush:**
  - Highest priority after reset.
  - Next state is EMPTY; `rem_q=0`.
  - `in_ready=0` during the flush cycle, so no input is accepted.
  - Any output handshake in that cycle still counts to the consumer, but the word is discarded.
- **Data path:** no other data is modified; lanes beyond `in_count` are never emitted.

## Timing

- **Reset values:** `out_valid=0`, `out_last=0`, `busy=0`, `in_ready=1` after the reset edge, `out_payload=0`. `in_ready` is held 0 while `rst_n=0`.
- **Reset mid-word:** held lanes are lost; no partial beat appears after release.
- **Latency:** word accepted at edge N gives its first beat valid in cycle N+1.
- **Throughput:** full `out_ready` gives one beat per cycle. A word of c lanes occupies exactly c cycles.
- **Combinational paths:**
  - `in_ready` depends combinationally on `out_ready` and `flush`.
  - `out_*` depend only on registers.

## Configuration

- **`STREAM_UNPACK_MSB_FIRST_EN` defined:**
  - Lanes are emitted from the highest valid lane downward: first lane `c-1`, then down to lane 0.
  - `idx_q` starts at `c-1` and decrements.
- **Not defined (default):**
  - Lanes are emitted from lane 0 upward to lane `c-1`.
  - `idx_q` starts at 0 and increments.
- Handshake, count, flush and timing behaviour are identical in both builds.

## Test plan

1. **Basic word:** reset with `rst_n=0` for 2 cycles, then push `in_payload=32'hDDCCBBAA`, `in_count=4`, `out_ready=1`. Required: beats `AA, BB, CC, DD` in cycles N+1..N+4, `out_last=1` only on `DD`. MSB-first build gives `DD, CC, BB, AA`.
2. **Back-to-back:** push `32'h44332211` then `32'h88776655`, both count 4, `in_valid=1` continuously, `out_ready=1`. Required: 8 consecutive beats `11..88` with no gap; the second word is accepted in the cycle `44` is consumed.
3. **Partial and zero count:** push count 2 of `32'hFFEE_BEEF`, then count 0, then count 7. Required: beats `EF, BE` (last on `BE`); the count-0 word is accepted with no beat; count 7 emits 4 beats.
4. **Backpressure:** push `32'h04030201`, hold `out_ready=0` for 3 cycles, then toggle 1/0. Required: `out_payload=01` held stable while stalled; sequence `01..04` intact; `in_ready=0` until the last beat handshakes.
5. **Flush and reset mid-word:**
   - Flush: after beat `01` of `32'h04030201`, pulse `flush` for 1 cycle. Required: `out_valid=0` the next cycle, `in_ready=0` during the flush, then 1.
   - Reset: repeat with `rst_n=0` instead of `flush`. Required: all outputs at reset values and no residual beats.

Source files
------------

// File: rtl/stream_unpacker_if.sv
// Wide-in / narrow-out stream bundle for stream_unpacker.
// The slave modport is the unpacker side; the master modport is the producer/consumer side.
interface stream_unpacker_if #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4
);
    localparam int CW = $clog2(RATIO) + 1;

    logic                       in_valid;
    logic                       in_ready;
    logic [OUT_WIDTH*RATIO-1:0] in_payload;
    logic [CW-1:0]              in_count;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [OUT_WIDTH-1:0]       out_payload;
    logic                       out_last;
    logic                       busy;

    modport master (
        output in_valid, in_payload, in_count, flush, out_ready,
        input  in_ready, out_valid, out_payload, out_last, busy
    );

    modport slave (
        input  in_valid, in_payload, in_count, flush, out_ready,
        output in_ready, out_valid, out_payload, out_last, busy
    );
endinterface

// File: rtl/stream_unpacker.sv
// Unpacks one RATIO-lane word into single-lane beats with a last-of-word flag.
// Define STREAM_UNPACK_MSB_FIRST_EN to emit lanes from the highest valid lane downward.
//
// state   | meaning
// S_EMPTY | no word held, input always ready
// S_HOLD  | word held, r_rem beats left, r_idx is the lane on the output
module stream_unpacker #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_unpacker_if.slave  bus
);
    localparam int IW = $clog2(RATIO);
    localparam int CW = IW + 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [OUT_WIDTH*RATIO-1:0] r_data;
    logic [OUT_WIDTH*RATIO-1:0] w_data_nxt;
    logic [CW-1:0]              r_rem;
    logic [CW-1:0]              w_rem_nxt;
    logic [IW-1:0]              r_idx;
    logic [IW-1:0]              w_idx_nxt;

    logic [CW-1:0]              w_cnt;
    logic [IW-1:0]              w_first_idx;
    logic [IW-1:0]              w_idx_step;
    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_out_hs;

    // Counts above RATIO saturate rather than wrap.
    assign w_cnt = (bus.in_count > CW'(RATIO)) ? CW'(RATIO) : bus.in_count;

`ifdef STREAM_UNPACK_MSB_FIRST_EN
    assign w_first_idx = IW'(w_cnt - CW'(1));
    assign w_idx_step  = r_idx - IW'(1);
`else
    assign w_first_idx = '0;
    assign w_idx_step  = r_idx + IW'(1);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
            r_rem   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_rem   <= w_rem_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_rem_nxt   = r_rem;
        w_idx_nxt   = r_idx;
        w_in_ready  = 1'b0;

        // Ready on the last beat's handshake keeps back-to-back words bubble-free.
        if (rst_n && !bus.flush) begin
            case (r_state)
                S_EMPTY: w_in_ready = 1'b1;
                S_HOLD:  w_in_ready = bus.out_ready && (r_rem == CW'(1));
                default: w_in_ready = 1'b0;
            endcase
        end

        w_accept = bus.in_valid && w_in_ready;
        w_out_hs = (r_state == S_HOLD) && bus.out_ready;

        if (bus.flush) begin
            w_state_nxt = S_EMPTY;
            w_rem_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            if (w_out_hs) begin
                if (r_rem > CW'(1)) begin
                    w_rem_nxt = r_rem - CW'(1);
                    w_idx_nxt = w_idx_step;
                end else begin
                    w_state_nxt = S_EMPTY;
                    w_rem_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            // A zero-count word is consumed here but never loaded.
            if (w_accept && (w_cnt != '0)) begin
                w_state_nxt = S_HOLD;
                w_data_nxt  = bus.in_payload;
                w_rem_nxt   = w_cnt;
                w_idx_nxt   = w_first_idx;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_state == S_HOLD);
    assign bus.busy        = (r_state == S_HOLD);
    assign bus.out_last    = (r_state == S_HOLD) && (r_rem == CW'(1));
    assign bus.out_payload = (r_state == S_HOLD) ? r_data[r_idx*OUT_WIDTH +: OUT_WIDTH]
                                                 : '0;
endmodule

// File: tb/tb_stream_unpacker.sv
// Self-checking bench for stream_unpacker: beat-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_stream_unpacker;
    localparam int W  = 8;
    localparam int R  = 4;
    localparam int CW = 3;
`ifdef STREAM_UNPACK_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_unpacker_if #(.OUT_WIDTH(W), .RATIO(R)) u_if ();

    stream_unpacker #(.OUT_WIDTH(W), .RATIO(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         cyc;
    } obs_t;

    beat_t mq[$];
    obs_t  obs[$];
    int    total = 0;
    int    bad   = 0;
    int    ncyc  = 0;
    bit    armed = 1'b0;

    function automatic int ord(input int k, input int c);
        return MSB ? (c - 1 - k) : k;
    endfunction

    function automatic logic exp_in_ready();
        return rst_n && !u_if.flush &&
               ((mq.size() == 0) || (u_if.out_ready && (mq.size() == 1)));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the list of beats still owed to the consumer.
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            armed = 1'b1;
        end else if (u_if.flush) begin
            mq.delete();
        end else begin
            logic acc;
            int   c;
            acc = u_if.in_valid && exp_in_ready();
            if ((mq.size() > 0) && u_if.out_ready) void'(mq.pop_front());
            if (acc) begin
                c = (int'(u_if.in_count) > R) ? R : int'(u_if.in_count);
                for (int k = 0; k < c; k++)
                    mq.push_back('{u_if.in_payload[ord(k, c)*W +: W], (k == c - 1)});
            end
        end
    end

    always @(negedge clk) begin
        ncyc++;
        if (armed) begin
            chk("in_ready", u_if.in_ready, exp_in_ready());
            chk("out_valid", u_if.out_valid, mq.size() > 0);
            chk("busy", u_if.busy, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("out_payload", u_if.out_payload, mq[0].d);
                chk("out_last", u_if.out_last, mq[0].l);
            end else begin
                chk("idle_payload", u_if.out_payload, 0);
                chk("idle_last", u_if.out_last, 0);
            end
            if (rst_n && u_if.out_valid && u_if.out_ready)
                obs.push_back('{u_if.out_payload, u_if.out_last, ncyc});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] p, input logic [CW-1:0] c, input string nm);
        bit done;
        done = 1'b0;
        u_if.in_valid   = 1'b1;
        u_if.in_payload = p;
        u_if.in_count   = c;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (u_if.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        u_if.in_valid = 1'b0;
        chk(nm, done, 1);
    endtask

    task automatic chk_obs(input string nm, input logic [7:0] ed[$], input logic el[$]);
        chk({nm, "_n"}, obs.size(), ed.size());
        for (int k = 0; k < ed.size() && k < obs.size(); k++) begin
            chk({nm, "_d"}, obs[k].d, ed[k]);
            chk({nm, "_l"}, obs[k].l, el[k]);
            chk({nm, "_gap"}, obs[k].cyc, obs[0].cyc + k);
        end
    endtask

    initial begin
        logic [7:0] ln[4];
        logic [7:0] ed[$];
        logic       el[$];
        int         t0;

        u_if.in_valid   = 1'b0;
        u_if.in_payload = '0;
        u_if.in_count   = '0;
        u_if.flush      = 1'b0;
        u_if.out_ready  = 1'b0;

        // Reset: two cycles low
        cyc(2);
        chk("rst_in_ready_low", u_if.in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", u_if.in_ready, 1);
        chk("rst_out_valid", u_if.out_valid, 0);
        chk("rst_payload", u_if.out_payload, 0);
        cyc(1);

        // Basic word
        obs.delete();
        u_if.out_ready = 1'b1;
        push(32'hDDCCBBAA, 3'd4, "t1_acc");
        t0 = ncyc;
        cyc(6);
        ln = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        ed.delete(); el.delete();
        for (int k = 0; k < 4; k++) begin
            ed.push_back(ln[ord(k, 4)]);
            el.push_back(k == 3);
        end
        chk_obs("t1", ed, el);
        if (obs.size() > 0) chk("t1_latency", obs[0].cyc, t0 + 1);

        // Back-to-back
        obs.delete();
        push(32'h44332211, 3'd4, "t2_acc0");
        push(32'h88776655, 3'd4, "t2_acc1");
        cyc(8);
        ed.delete(); el.delete();
        for (int k = 0; k < 8; k++) begin
            ed.push_back(8'(8'h11 * ((k / 4) * 4 + ord(k % 4, 4) + 1)));
            el.push_back((k % 4) == 3);
        end
        chk_obs("t2", ed, el);

        // Partial, zero and oversized counts
        obs.delete();
        push(32'hFFEEBEEF, 3'd2, "t3_acc2");
        push(32'h11223344, 3'd0, "t3_acc0");
        push(32'h04030201, 3'd7, "t3_acc7");
        cyc(8);
        ed.delete(); el.delete();
        ln = '{8'hEF, 8'hBE, 8'h00, 8'h00};
        for (int k = 0; k < 2; k++) begin
            ed.push_back(ln[ord(k, 2)]);
            el.push_back(k == 1);
        end
        ln = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int k = 0; k < 4; k++) begin
            ed.push_back(ln[ord(k, 4)]);
            el.push_back(k == 3);
        end
        chk("t3_n", obs.size(), 6);
        for (int k = 0; k < 6 && k < obs.size(); k++) begin
            chk("t3_d", obs[k].d, ed[k]);
            chk("t3_l", obs[k].l, el[k]);
        end

        // Backpressure
        obs.delete();
        u_if.out_ready = 1'b0;
        push(32'h04030201, 3'd4, "t4_acc");
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall_d", u_if.out_payload, ln[ord(0, 4)]);
            chk("t4_stall_rdy", u_if.in_ready, 0);
        end
        cyc(1);
        for (int i = 0; i < 10; i++) begin
            u_if.out_ready = ~u_if.out_ready;
            cyc(1);
        end
        u_if.out_ready = 1'b1;
        cyc(4);
        chk("t4_n", obs.size(), 4);
        for (int k = 0; k < 4 && k < obs.size(); k++)
            chk("t4_d", obs[k].d, ln[ord(k, 4)]);

        // Flush mid-word
        obs.delete();
        push(32'h04030201, 3'd4, "t5_acc");
        cyc(1);
        u_if.flush      = 1'b1;
        u_if.in_valid   = 1'b1;
        u_if.in_payload = 32'hA5A5A5A5;
        u_if.in_count   = 3'd4;
        @(negedge clk);
        chk("t5_flush_rdy", u_if.in_ready, 0);
        cyc(1);
        u_if.flush    = 1'b0;
        u_if.in_valid = 1'b0;
        @(negedge clk);
        chk("t5_post_valid", u_if.out_valid, 0);
        chk("t5_post_rdy", u_if.in_ready, 1);
        cyc(4);
        chk("t5_beats", obs.size(), 2);

        // Reset mid-word
        obs.delete();
        push(32'h04030201, 3'd4, "t6_acc");
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_valid", u_if.out_valid, 0);
        chk("t6_payload", u_if.out_payload, 0);
        chk("t6_last", u_if.out_last, 0);
        chk("t6_busy", u_if.busy, 0);
        chk("t6_rdy", u_if.in_ready, 1);
        cyc(5);
        chk("t6_beats", obs.size(), 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            u_if.in_valid   = ($urandom_range(0, 3) != 0);
            u_if.in_payload = $urandom;
            u_if.in_count   = CW'($urandom_range(0, 7));
            u_if.out_ready  = ($urandom_range(0, 3) != 0);
            u_if.flush      = ($urandom_range(0, 29) == 0);
            rst_n           = ($urandom_range(0, 149) != 0);
            cyc(1);
        end
        rst_n          = 1'b1;
        u_if.flush     = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        cyc(8);
        chk("drain_valid", u_if.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
